// File: rtl/alu_div_pkg.sv
// Shared encodings for the divider: controller state codes and the one-hot
// Control word understood by the datapath.
package alu_div_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    CHECK  = 3'd3,
    SUB    = 3'd4,
    SETTLE = 3'd5,
    FIN    = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam logic [2:0] CTL_HOLD  = 3'b000;
  localparam logic [2:0] CTL_LOAD  = 3'b100;
  localparam logic [2:0] CTL_SHIFT = 3'b010;
  localparam logic [2:0] CTL_SUB   = 3'b001;

  function automatic logic [2:0] ctl_of(input state_t s);
    case (s)
      LOAD:    ctl_of = CTL_LOAD;
      SHIFT:   ctl_of = CTL_SHIFT;
      SUB:     ctl_of = CTL_SUB;
      default: ctl_of = CTL_HOLD;
    endcase
  endfunction

  function automatic logic busy_of(input state_t s);
    busy_of = (s == LOAD) || (s == SHIFT) || (s == CHECK) ||
              (s == SUB)  || (s == SETTLE);
  endfunction

endpackage

// File: rtl/divisor_control.sv
// Restoring-divider controller: sequences load/shift/subtract on the datapath,
// cross-checks its iteration count, and reports Busy/Valid/Error.
module divisor_control
  import alu_div_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] B,
  input  logic             Comp,
  input  logic             Done,
  output logic [2:0]       Control,
  output logic             Busy,
  output logic             Valid,
  output logic             Error
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_control;
  logic             r_busy;
  logic             r_valid;
  logic             r_error;
  logic             w_mismatch;

  // Our counter and the datapath's Done flag must reach zero together.
  always_comb begin
    w_mismatch = (Done && (r_cnt != '0)) || (!Done && (r_cnt == '0));
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (Start) w_next = (B == '0) ? ERR : LOAD;
      LOAD:    w_next = SHIFT;
      SHIFT:   w_next = CHECK;
      CHECK: begin
        if (w_mismatch)  w_next = ERR;
        else if (!Comp)  w_next = SUB;
        else if (!Done)  w_next = SHIFT;
        else             w_next = SETTLE;
      end
      SUB: begin
        if (w_mismatch)  w_next = ERR;
        else if (Done)   w_next = SETTLE;
        else             w_next = SHIFT;
      end
      SETTLE:  w_next = FIN;
      FIN,
      ERR:     if (!Start) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops aligned with it.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_control <= CTL_HOLD;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_control <= ctl_of(w_next);
      r_busy    <= busy_of(w_next);
      r_valid   <= (w_next == FIN);
      r_error   <= (w_next == ERR);
      if (r_state == LOAD)       r_cnt <= CNT_LOAD;
      else if (r_state == SHIFT) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign Control = r_control;
  assign Busy    = r_busy;
  assign Valid   = r_valid;
  assign Error   = r_error;

endmodule
